modulo_decod_ff_t: RTL and testbench

MODULO_DECOD_FF_T -- requirements
Module: modulo_decod_ff_t

---
 rtl/modulo_decod_ff_t.sv | 113 +++++++++++
 tb/tb_modulo_decod_ff_t.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_decod_ff_t.sv
// Toggle-line event decoder: synchronizes a remote T-flop level, turns each level change into a
// pulse and a pending-event count with ack handshake. Define DECOD_FF_T_OVF_EN for the sticky overflow flag.
module modulo_decod_ff_t #(
  parameter int   SYNC_STAGES = 2,
  parameter int   CW          = 4,
  parameter logic INIT_LEVEL  = 1'b1
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          enable,
  input  logic          t_in,
  input  logic          evt_ack,
`ifdef DECOD_FF_T_OVF_EN
  input  logic          clr_ovf,
`endif
  output logic          pulse_out,
  output logic          evt_valid,
  output logic [CW-1:0] pend_count,
  output logic [1:0]    estado,
  output logic          overflow
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    PENDENTE = 2'b01,
    CHEIO    = 2'b10
  } estado_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_level;
  logic                   last_level_q;
  logic                   change;
  logic                   evt_q;
  logic                   pulse_q;
  logic                   ack;
  logic [CW-1:0]          count_q, count_d;
  estado_t                state_q, state_d;
  logic                   valid_q, valid_d;

  assign sync_level = sync_q[SYNC_STAGES-1];
  assign change     = sync_level ^ last_level_q;
  assign ack        = evt_ack & valid_q;

  // evt_q adds one stage so the pulse lands SYNC_STAGES+1 edges after t_in is first sampled.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q       <= {SYNC_STAGES{INIT_LEVEL}};
      last_level_q <= INIT_LEVEL;
      evt_q        <= 1'b0;
      pulse_q      <= 1'b0;
      count_q      <= '0;
      state_q      <= OCIOSO;
      valid_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], t_in};
      last_level_q <= sync_level;
      evt_q        <= change & enable;
      pulse_q      <= evt_q;
      count_q      <= count_d;
      state_q      <= state_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    count_d = count_q;
    state_d = OCIOSO;
    unique case ({evt_q, ack})
      2'b10:   if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    case (state_q)
      OCIOSO, PENDENTE, CHEIO: begin
        if (count_d == '0)          state_d = OCIOSO;
        else if (count_d == CNT_MAX) state_d = CHEIO;
        else                         state_d = PENDENTE;
      end
      // Unreachable encoding 11: recover to an empty, idle decoder.
      default: begin
        count_d = '0;
        state_d = OCIOSO;
      end
    endcase
    valid_d = (count_d != '0);
  end

`ifdef DECOD_FF_T_OVF_EN
  logic lost;
  logic ovf_q;

  assign lost = evt_q & ~ack & (count_q == CNT_MAX);

  // A loss in the same cycle as clr_ovf wins, so no lost event goes unreported.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) ovf_q <= 1'b0;
    else        ovf_q <= lost | (ovf_q & ~clr_ovf);
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign pulse_out  = pulse_q;
  assign evt_valid  = valid_q;
  assign pend_count = count_q;
  assign estado     = state_q;

endmodule

// File: tb/tb_modulo_decod_ff_t.sv
// Self-checking bench for modulo_decod_ff_t: an event-history reference model checked every
// cycle, plus directed scenarios with hand-computed expectations and a randomized phase.
module tb_modulo_decod_ff_t;

  localparam int   S    = 2;
  localparam int   CW   = 4;
  localparam logic INIT = 1'b1;
  localparam int   MAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          enable;
  logic          t_in;
  logic          evt_ack;
`ifdef DECOD_FF_T_OVF_EN
  logic          clr_ovf;
`endif
  logic          pulse_out;
  logic          evt_valid;
  logic [CW-1:0] pend_count;
  logic [1:0]    estado;
  logic          overflow;

  modulo_decod_ff_t #(.SYNC_STAGES(S), .CW(CW), .INIT_LEVEL(INIT)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .enable     (enable),
    .t_in       (t_in),
    .evt_ack    (evt_ack),
`ifdef DECOD_FF_T_OVF_EN
    .clr_ovf    (clr_ovf),
`endif
    .pulse_out  (pulse_out),
    .evt_valid  (evt_valid),
    .pend_count (pend_count),
    .estado     (estado),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses_seen = 0;

  // Reference model: history of sampled t_in levels (bit 0 newest) plus the event counter.
  logic [S+1:0] hist;
  logic         en_prev;
  int           cnt;
  logic         ovf;
  logic         exp_pulse;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int exp_state(input int c);
    if (c == 0)   return 0;
    if (c == MAX) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    hist      = '1;
    if (INIT == 1'b0) hist = '0;
    en_prev   = 1'b0;
    cnt       = 0;
    ovf       = 1'b0;
    exp_pulse = 1'b0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare all outputs.
  task automatic tick();
    logic ack_ok;
    logic lost;
    @(posedge clk);
    if (!clr_n) begin
      model_reset();
    end else begin
      // A level change that has crossed the synchronizer is reported one edge after detection.
      exp_pulse = (hist[S] != hist[S+1]) && en_prev;
      ack_ok    = evt_ack && (cnt != 0);
      lost      = 1'b0;
      if (exp_pulse && !ack_ok) begin
        if (cnt == MAX) lost = 1'b1;
        else            cnt++;
      end else if (!exp_pulse && ack_ok) begin
        cnt--;
      end
`ifdef DECOD_FF_T_OVF_EN
      if (lost)         ovf = 1'b1;
      else if (clr_ovf) ovf = 1'b0;
`else
      ovf = 1'b0;
`endif
      hist    = {hist[S:0], t_in};
      en_prev = enable;
    end
    #1;
    if (pulse_out) pulses_seen++;
    chk("pulse_out", pulse_out, exp_pulse);
    chk("pend_count", pend_count, cnt);
    chk("evt_valid", evt_valid, cnt != 0);
    chk("estado", estado, exp_state(cnt));
    chk("overflow", overflow, ovf);
  endtask

  task automatic drain();
    evt_ack = 1'b1;
    repeat (MAX + 2) tick();
    evt_ack = 1'b0;
    chk("drain_count", pend_count, 0);
  endtask

  initial begin
    clr_n   = 1'b0;
    enable  = 1'b1;
    t_in    = 1'b1;
    evt_ack = 1'b0;
`ifdef DECOD_FF_T_OVF_EN
    clr_ovf = 1'b0;
`endif
    model_reset();
    #1;
    chk("reset_count", pend_count, 0);
    chk("reset_estado", estado, 0);
    chk("reset_pulse", pulse_out, 0);
    repeat (2) tick();
    clr_n = 1'b1;

    // Idle after release with t_in at the power-up level: nothing happens.
    pulses_seen = 0;
    repeat (20) tick();
    chk("idle_pulses", pulses_seen, 0);
    chk("idle_count", pend_count, 0);
    chk("idle_estado", estado, 0);
    $display("scenario idle: pulses=%0d count=%0d", pulses_seen, pend_count);

    // 1->0 first sampled at edge k: pulse only at edge k+3.
    t_in = 1'b0;
    tick(); chk("lat_k0", pulse_out, 0);
    tick(); chk("lat_k1", pulse_out, 0);
    tick(); chk("lat_k2", pulse_out, 0);
    tick(); chk("lat_k3", pulse_out, 1);
    chk("lat_count", pend_count, 1);
    chk("lat_estado", estado, 1);
    $display("scenario latency: count=%0d estado=%0d", pend_count, estado);

    // 15 more back-to-back toggles: 16 events total, one lost at saturation.
    for (int i = 0; i < 15; i++) begin
      t_in = ~t_in;
      tick();
    end
    repeat (4) tick();
    chk("sat_count", pend_count, 15);
    chk("sat_estado", estado, 2);
`ifdef DECOD_FF_T_OVF_EN
    chk("sat_overflow", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_overflow", overflow, 0);
`else
    chk("sat_overflow", overflow, 0);
`endif
    $display("scenario saturate: count=%0d overflow=%0d", pend_count, overflow);

    // Event and ack on the same edge at saturation: count holds, nothing lost.
    t_in = ~t_in;
    tick(); tick(); tick();
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    chk("evack_pulse", pulse_out, 1);
    chk("evack_count", pend_count, 15);
    chk("evack_overflow", overflow, 0);
    $display("scenario event+ack: count=%0d overflow=%0d", pend_count, overflow);

    drain();

    // Disabled toggles are discarded and cause no burst on re-enable.
    enable = 1'b0;
    pulses_seen = 0;
    for (int i = 0; i < 3; i++) begin
      t_in = ~t_in;
      tick(); tick();
    end
    repeat (5) tick();
    enable = 1'b1;
    repeat (3) tick();
    chk("dis_pulses", pulses_seen, 0);
    chk("dis_count", pend_count, 0);
    t_in = ~t_in;
    repeat (8) tick();
    chk("reen_pulses", pulses_seen, 1);
    chk("reen_count", pend_count, 1);
    $display("scenario enable: pulses=%0d count=%0d", pulses_seen, pend_count);

    drain();

    // Randomized traffic with phases of differing ack pressure.
    for (int blk = 0; blk < 4; blk++) begin
      int ack_pct;
      ack_pct = (blk == 0) ? 0 : (blk == 1) ? 50 : (blk == 2) ? 90 : 30;
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(99) < 50) t_in = ~t_in;
        enable  = ($urandom_range(99) < 90);
        evt_ack = ($urandom_range(99) < ack_pct);
`ifdef DECOD_FF_T_OVF_EN
        clr_ovf = ($urandom_range(99) < 5);
`endif
        tick();
      end
      $display("scenario random block %0d: count=%0d", blk, pend_count);
    end
    evt_ack = 1'b0;
    enable  = 1'b1;
`ifdef DECOD_FF_T_OVF_EN
    clr_ovf = 1'b0;
`endif
    repeat (6) tick();
    drain();

    // Asynchronous reset mid-cycle with five events pending.
    for (int i = 0; i < 5; i++) begin
      t_in = ~t_in;
      tick(); tick();
    end
    repeat (5) tick();
    chk("pre_reset_count", pend_count, 5);
    #3;
    clr_n = 1'b0;
    #1;
    chk("async_pulse", pulse_out, 0);
    chk("async_count", pend_count, 0);
    chk("async_valid", evt_valid, 0);
    chk("async_estado", estado, 0);
    chk("async_overflow", overflow, 0);
    model_reset();
    #1;
    clr_n = 1'b1;
    repeat (12) tick();
    $display("scenario async reset: count=%0d", pend_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
